// File: rtl/ifu_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "defines.svh"

package ifu_prefetch_buf_pkg;

  localparam int AW = `INST_ADDR_WIDTH;
  localparam int DW = `INST_DATA_WIDTH;

  localparam logic [DW-1:0] INST_NOP = `INST_NOP;

  // One queued instruction: fetched word, its address, and bus-error flag.
  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] addr;
    logic          err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Force a byte address down to its containing word.
  function automatic logic [AW-1:0] word_align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/defines.svh
`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH

`define INST_NOP        32'h0000_0013
`define INST_ADDR_WIDTH 32
`define INST_DATA_WIDTH 32

`endif

// File: rtl/ifu_sync_fifo.sv
// Generic synchronous FIFO with single-cycle flush; head is read combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push while full and pop while empty are ignored; flush wins over push/pop.
module ifu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push     = i_push && (r_count != CW'(DEPTH));
  assign w_pop      = i_pop && (r_count != '0);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Sequential instruction prefetcher feeding decode through a small FIFO, with redirect flush.
// Latency: memory response -> inst_* next cycle; redirect -> new-PC request next cycle.
// Backpressure: inst_ready_i low fills the FIFO; credits then stop imem requests (no response stall).
module ifu_prefetch_buf
  import ifu_prefetch_buf_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;

  logic          w_can_issue;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_keep;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_ifq_addr;
  logic          w_ifq_empty;
  logic [OW-1:0] w_ifq_count;
  logic          w_unused_addr_lsb;

  // Byte offset of the redirect target is meaningless for word fetches.
  assign w_unused_addr_lsb = ^redirect_addr_i[1:0];

  // Credit check: every slot counted as either queued or owed, so a response always fits.
  assign w_can_issue = ((32'(w_fifo_count) + 32'(r_outstanding)) < DEPTH)
                    && (32'(r_outstanding) < MAX_OUTSTANDING);

  assign imem_req_o  = w_can_issue && !redirect_i && !rst;
  assign imem_addr_o = r_pc;

  assign w_gnt  = imem_req_o && imem_gnt_i;
  // A response with nothing owed is a protocol error and is ignored.
  assign w_rsp  = imem_rvalid_i && (r_outstanding != '0);
  // Responses owed to a pre-redirect stream, or arriving on a redirect cycle, are dropped.
  assign w_keep = w_rsp && (r_discard == '0) && !redirect_i;
  assign w_pop  = inst_valid_o && inst_ready_i && !redirect_i;

  assign w_push_entry = '{inst: imem_rdata_i, addr: w_ifq_addr, err: imem_err_i};

  ifu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_i),
    .i_push     (w_keep),
    .i_push_dat (w_push_entry),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  // Addresses of granted fetches; kept across redirects so discarded responses still pop in order.
  ifu_sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight_q (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (1'b0),
    .i_push     (w_gnt),
    .i_push_dat (r_pc),
    .i_pop      (w_rsp),
    .o_head_dat (w_ifq_addr),
    .o_empty    (w_ifq_empty),
    .o_count    (w_ifq_count)
  );

  // Fetch PC: redirect target overrides sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= word_align(redirect_addr_i);
    end else if (w_gnt) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Granted-but-unanswered count; simultaneous grant and response cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Responses still owed to a flushed stream; recomputed on every redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_discard <= '0;
    end else if (redirect_i) begin
      r_discard <= r_outstanding - OW'(w_rsp);
    end else if (w_rsp && (r_discard != '0)) begin
      r_discard <= r_discard - 1'b1;
    end
  end

  // Protocol and bookkeeping consistency checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid_i && (r_outstanding == '0)));
      assert (32'(w_ifq_count) == 32'(r_outstanding));
      assert (w_ifq_empty == (r_outstanding == '0));
      assert (r_discard <= r_outstanding);
    end
  end

  // Head presentation; idle values shown when nothing is queued.
  always_comb begin
    inst_valid_o = !w_fifo_empty;
    inst_o       = INST_NOP;
    inst_addr_o  = '0;
    inst_err_o   = 1'b0;
    if (!w_fifo_empty) begin
      inst_o      = w_head.inst;
      inst_addr_o = w_head.addr;
      inst_err_o  = w_head.err;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Directed scoreboard bench for ifu_prefetch_buf with a latency-configurable memory model.
// Latency: checks response-to-output of one cycle and redirect restart timing.
// Backpressure: exercises decode stall, full FIFO and request throttling.
module tb_ifu_prefetch_buf;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0080;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_err_o;

  always #5 clk = ~clk;

  ifu_prefetch_buf #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .imem_err_i      (imem_err_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .inst_addr_o     (inst_addr_o),
    .inst_err_o      (inst_err_o)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    bit          drop;
  } mreq_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_pop = 0;
  int          n_err_pop = 0;
  logic [31:0] last_pop_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] err_addr = 32'h0000_0001;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: check request address and handshake, update memory model and scoreboard.
  task automatic sample();
    mreq_t m;
    exp_t  e;
    @(negedge clk);
    if (!rst && inst_valid_o && inst_ready_i && !redirect_i) begin
      chk("pop_has_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_inst", inst_o, e.inst);
        chk("pop_addr", inst_addr_o, e.addr);
        chk("pop_err", 32'(inst_err_o), 32'(e.err));
      end
      n_pop++;
      last_pop_addr = inst_addr_o;
      if (inst_err_o) n_err_pop++;
    end
    if (imem_rvalid_i && mem_q.size() != 0) begin
      m = mem_q.pop_front();
      if (!m.drop && !redirect_i) sb.push_back('{m.data, m.addr, m.err});
    end
    if (!rst && imem_req_o) begin
      chk("req_addr", imem_addr_o, exp_pc);
      if (imem_gnt_i) begin
        m = '{cyc + lat, exp_pc, mem_data(exp_pc), exp_pc == err_addr, 1'b0};
        mem_q.push_back(m);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (!rst && redirect_i) begin
      chk("req_low_on_redirect", 32'(imem_req_o), 32'd0);
      foreach (mem_q[i]) mem_q[i].drop = 1'b1;
      sb.delete();
      exp_pc = {redirect_addr_i[31:2], 2'b00};
    end
  endtask

  // Clock edge, then drive this cycle's memory response.
  task automatic advance();
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_q[0].data;
      imem_err_i    = mem_q[0].err;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      imem_err_i    = 1'b0;
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    int k;
    int p0;
    int exp_disc;
    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    imem_err_i = 1'b0;
    inst_ready_i = 1'b1;

    // Reset values.
    tick();
    sample();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, NOP_WORD);
    chk("rst_addr", inst_addr_o, 32'd0);
    chk("rst_err", 32'(inst_err_o), 32'd0);
    advance();
    rst = 1'b0;

    // First request right after reset, first instruction two cycles later.
    sample();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RST_PC);
    advance();
    sample();
    chk("no_bypass_valid", 32'(inst_valid_o), 32'd0);
    advance();
    sample();
    chk("first_valid", 32'(inst_valid_o), 32'd1);
    chk("first_inst_addr", inst_addr_o, RST_PC);
    advance();

    // Sustained throughput with 1-cycle memory.
    p0 = n_pop;
    repeat (10) tick();
    chk("throughput", 32'(n_pop - p0), 32'd10);

    // Decode backpressure: FIFO fills, requests stop, head held.
    inst_ready_i = 1'b0;
    repeat (9) begin
      sample();
      if (inst_valid_o) begin
        chk("hold_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("hold_head", inst_addr_o, sb[0].addr);
      end
      advance();
    end
    sample();
    chk("bp_valid", 32'(inst_valid_o), 32'd1);
    chk("bp_req_low", 32'(imem_req_o), 32'd0);
    chk("bp_depth", 32'(sb.size()), 32'(DEPTH));
    if (sb.size() != 0) chk("bp_head", inst_addr_o, sb[0].addr);
    advance();
    inst_ready_i = 1'b1;
    repeat (8) tick();

    // Redirect with two fetches in flight, 3-cycle memory.
    lat = 3;
    for (k = 0; k < 20; k++) begin
      if (mem_q.size() == 2) break;
      tick();
    end
    chk("reach_two_inflight", 32'(k < 20), 32'd1);
    exp_disc = mem_q.size() - int'(imem_rvalid_i);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h0000_1003;
    sample();
    advance();
    redirect_i = 1'b0;
    chk("discard_two", 32'(dut.r_discard), 32'(exp_disc));
    p0 = n_pop;
    for (k = 0; k < 20; k++) begin
      if (n_pop != p0) break;
      tick();
    end
    chk("redir_pop_seen", 32'(k < 20), 32'd1);
    chk("redir_first_pop", last_pop_addr, 32'h0000_1000);
    repeat (6) tick();

    // Redirect coinciding with a response and a pop, 1-cycle memory.
    lat = 1;
    repeat (8) tick();
    for (k = 0; k < 10; k++) begin
      if (imem_rvalid_i && inst_valid_o) break;
      tick();
    end
    chk("find_rsp_pop_cycle", 32'(k < 10), 32'd1);
    exp_disc = mem_q.size() - int'(imem_rvalid_i);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h0000_2000;
    sample();
    advance();
    redirect_i = 1'b0;
    chk("discard_rsp_cycle", 32'(dut.r_discard), 32'(exp_disc));
    sample();
    chk("flush_empty", 32'(inst_valid_o), 32'd0);
    chk("restart_req", 32'(imem_req_o), 32'd1);
    chk("restart_addr", imem_addr_o, 32'h0000_2000);
    advance();
    sample();
    chk("restart_not_yet", 32'(inst_valid_o), 32'd0);
    advance();
    sample();
    chk("restart_valid", 32'(inst_valid_o), 32'd1);
    chk("restart_inst_addr", inst_addr_o, 32'h0000_2000);
    advance();

    // Bus error on the last word of the address space, then wrap to zero.
    err_addr = 32'hFFFF_FFFC;
    redirect_i = 1'b1;
    redirect_addr_i = 32'hFFFF_FFF4;
    p0 = n_err_pop;
    tick();
    redirect_i = 1'b0;
    repeat (12) tick();
    chk("err_once", 32'(n_err_pop - p0), 32'd1);

    // Stop granting, drain everything.
    imem_gnt_i = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (sb.size() == 0 && mem_q.size() == 0 && !inst_valid_o) break;
      tick();
    end
    chk("drain_done", 32'(k < 20), 32'd1);
    sample();
    chk("drain_valid", 32'(inst_valid_o), 32'd0);
    chk("drain_inst_nop", inst_o, NOP_WORD);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
